// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - default operand width
//   - operation codes carried on the 'op' input
//   - FSM state encoding, 2 bits
package alu_pkg;

  localparam int W_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/alu_addsub.sv
// Shared W-bit adder/subtractor.
// Ports:
//   a, b  : W-bit operands
//   binv  : invert B before the add (subtract = binv plus cin=1)
//   cin   : carry-in
//   sum   : W-bit result
//   cout  : carry-out (for subtract, 1 means no borrow)
module alu_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         binv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff = binv ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer.
// One add/subtract path is shared by both operations; the sequencer owns the
// B-invert control of that adder.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last result
// RUN   | one iteration per clock, W iterations
// FIN   | done pulse, results valid; start ignored
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, op    : request pulse (sampled in IDLE), 0=MUL 1=DIV
//   a, b         : multiplicand/dividend, multiplier/divisor
//   busy, done   : busy in RUN/FIN, one-cycle done in FIN
//   hi, lo       : MUL product high/low, DIV remainder/quotient
//   div_by_zero  : DIV with b==0, held until next accepted start
//   binv         : B-invert currently applied to the shared adder
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_by_zero,
  output logic         binv
);

  localparam int CW = $clog2(W + 1);

  logic [1:0]    state_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  b_q;
  logic          op_q;
  logic          dbz_q;

  logic [W-1:0]  add_x;
  logic [W-1:0]  add_y;
  logic          add_binv;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_c;
  logic          div_accept;

  // Adder operand steering. Outside RUN the adder sees zeros so binv is 0.
  always_comb begin
    add_x    = '0;
    add_y    = '0;
    add_binv = 1'b0;
    add_cin  = 1'b0;
    if (state_q == ST_RUN) begin
      if (op_q == OP_DIV) begin
        add_x    = {hi_q[W-2:0], lo_q[W-1]};
        add_y    = b_q;
        add_binv = 1'b1;
        add_cin  = 1'b1;
      end else begin
        add_x = hi_q;
        add_y = lo_q[0] ? b_q : '0;
      end
    end
  end

  alu_addsub #(.W(W)) u_addsub (
    .a    (add_x),
    .b    (add_y),
    .binv (add_binv),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_c)
  );

  // The bit shifted out of hi is the 33rd remainder bit; when set the partial
  // remainder certainly exceeds b, so the subtract must be taken.
  assign div_accept = add_c | hi_q[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            b_q   <= b;
            dbz_q <= 1'b0;
            if (op == OP_DIV && b == '0) begin
              hi_q    <= a;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              count_q <= '0;
              state_q <= ST_FIN;
            end else begin
              hi_q    <= '0;
              lo_q    <= a;
              count_q <= CW'(W);
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          count_q <= count_q - CW'(1);
          if (op_q == OP_DIV) begin
            hi_q <= div_accept ? add_sum : {hi_q[W-2:0], lo_q[W-1]};
            lo_q <= {lo_q[W-2:0], div_accept};
          end else begin
            // 2W+1-bit right shift of {carry, sum, lo}
            hi_q <= {add_c, add_sum[W-1:1]};
            lo_q <= {add_sum[0], lo_q[W-1:1]};
          end
          if (count_q == CW'(1)) state_q <= ST_FIN;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign done        = (state_q == ST_FIN);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign binv        = add_binv;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic         binv;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .binv        (binv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent reference model pushed to the scoreboard at stimulus time.
  task automatic push_expect(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [63:0] p;
    if (o == 1'b0) begin
      p     = 64'(av) * 64'(bv);
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dbz = 1'b0;
      e.lat = W;
    end else if (bv == '0) begin
      e.hi  = av;
      e.lo  = '1;
      e.dbz = 1'b1;
      e.lat = 0;
    end else begin
      e.hi  = av % bv;
      e.lo  = av / bv;
      e.dbz = 1'b0;
      e.lat = W;
    end
    exp_q.push_back(e);
  endtask

  // Issue one op at the current negedge; optionally pulse start during RUN
  // and FIN with other operands, which must be ignored.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit inject);
    int n;
    int binv_bad;
    exp_t e;
    start = 1'b1; op = o; a = av; b = bv;
    push_expect(o, av, bv);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    check({tag, " busy"}, 64'(busy), 64'(1));
    n = 0;
    binv_bad = 0;
    while (!done && n < 100) begin
      if (binv !== ((o == 1'b1) ? 1'b1 : 1'b0)) binv_bad++;
      @(negedge clk);
      n++;
      if (inject && n == 5) begin
        start = 1'b1; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
      end else if (inject && n == 6) begin
        start = 1'b0;
      end
    end
    check({tag, " binv_run"}, 64'(binv_bad), 64'(0));
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, " latency"}, 64'(n), 64'(e.lat));
      check({tag, " hi"}, 64'(hi), 64'(e.hi));
      check({tag, " lo"}, 64'(lo), 64'(e.lo));
      check({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
      check({tag, " binv_fin"}, 64'(binv), 64'(0));
    end
    if (inject) begin
      start = 1'b1; op = 1'b0; a = 32'h0000_0009; b = 32'h0000_0009;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_one_cycle"}, {62'(0), done, busy}, 64'(0));
    if (e.lat >= 0) begin
      check({tag, " hold"}, {hi, lo}, {e.hi, e.lo});
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {hi, lo}, 64'(0));
    check("reset_flags", {60'(0), busy, done, div_by_zero, binv}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b0);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0);
    run_op("div_big_divisor", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op("div_by_zero", 1'b1, 32'h0000_1234, 32'h0, 1'b0);
    run_op("mul_after_dbz", 1'b0, 32'h0001_0003, 32'h0000_0100, 1'b0);
    run_op("div_ignore_start", 1'b1, 32'd100, 32'd7, 1'b1);
    run_op("mul_next_idle", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op("div_small_by_big", 1'b1, 32'd5, 32'hFFFF_FFF0, 1'b0);

    // Async reset during RUN iteration 10.
    start = 1'b1; op = 1'b0; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", {hi, lo}, 64'(0));
    check("async_reset_flags", {60'(0), busy, done, div_by_zero, binv}, 64'(0));
    @(negedge clk);
    check("reset_held_idle", {62'(0), busy, done}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul_3x5_after_reset", 1'b0, 32'd3, 32'd5, 1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
